// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR stream checker.
//   checker_state_t : the checker's synchronisation states (HUNT, VERIFY, LOCKED)
//   run_width()     : width of the run counter. It must hold the larger of the
//                     lock and unlock thresholds.
// No ports; imported by the checker and the step-function module.
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } checker_state_t;

    function automatic int run_width(input int lock_count, input int unlock_count);
        int largest;
        largest = (lock_count > unlock_count) ? lock_count : unlock_count;
        return $clog2(largest + 1);
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// -----------------------------------------------------------------------------
// lfsr_next
// Pure combinational Galois LFSR step. The generator uses the same module, so
// the checker's predictions always use exactly the generator's tap semantics.
// Ports:
//   state      in   WIDTH  current LFSR state
//   next_state out  WIDTH  state after one advance
// Tap rule: for i < WIDTH-1, next[i] = TAPS[i] ? s[0]^s[i+1] : s[i+1];
//           next[WIDTH-1] = s[0]. TAPS[WIDTH-1] is not used.
// -----------------------------------------------------------------------------
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h8E
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    always_comb begin
        next_state = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            next_state[i] = TAPS[i] ? (state[0] ^ state[i+1]) : state[i+1];
        end
        next_state[WIDTH-1] = state[0];
    end

endmodule

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Receiving end of an LFSR word stream. It hunts for a nonzero seed and then
// verifies LOCK_COUNT consecutive predictions. After that it locks and runs
// as a flywheel: once locked, the input is never used to reseed.
// Ports:
//   clock      in   1          rising-edge clock
//   reset      in   1          synchronous, active-high
//   in_valid   in   1          in_word carries a new LFSR state
//   in_word    in   WIDTH      received LFSR state
//   err_clear  in   1          clear the error counter
//   locked     out  1          high while in LOCKED (registered)
//   mismatch   out  1          one-cycle pulse per bad word while locked
//   err_count  out  ERR_WIDTH  saturating count of locked mismatches
// All outputs reflect the word accepted on the previous clock edge.
// -----------------------------------------------------------------------------
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'h8E,
    parameter int               LOCK_COUNT   = 4,
    parameter int               UNLOCK_COUNT = 3,
    parameter int               ERR_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_word,
    input  logic                 err_clear,
    output logic                 locked,
    output logic                 mismatch,
    output logic [ERR_WIDTH-1:0] err_count
);

    localparam int RW = run_width(LOCK_COUNT, UNLOCK_COUNT);

    checker_state_t       state, state_n;
    logic [WIDTH-1:0]     expect_word, expect_word_n;
    logic [RW-1:0]        run, run_n, run_inc;
    logic                 mismatch_n;
    logic [ERR_WIDTH-1:0] err_count_n, err_base;
    logic                 count_err;
    logic [WIDTH-1:0]     seed_next, expect_step;
    logic                 word_match;

    // The seed path predicts from the received word. The flywheel path
    // predicts from our own expectation.
    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_seed_next (
        .state      (in_word),
        .next_state (seed_next)
    );

    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_expect_next (
        .state      (expect_word),
        .next_state (expect_step)
    );

    assign word_match = (in_word == expect_word);
    assign run_inc    = run + RW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HUNT;
            expect_word <= '0;
            run         <= '0;
            locked      <= 1'b0;
            mismatch    <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_n;
            expect_word <= expect_word_n;
            run         <= run_n;
            locked      <= (state_n == LOCKED);
            mismatch    <= mismatch_n;
            err_count   <= err_count_n;
        end
    end

    // Next-state logic. All-zero is never a legal LFSR state, so a zero
    // word is never used as a seed.
    always_comb begin
        state_n       = state;
        expect_word_n = expect_word;
        run_n         = run;
        mismatch_n    = 1'b0;
        count_err     = 1'b0;

        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_word != '0) begin
                        expect_word_n = seed_next;
                        run_n         = '0;
                        state_n       = VERIFY;
                    end
                end
                VERIFY: begin
                    if (word_match) begin
                        expect_word_n = expect_step;
                        if (run_inc == RW'(LOCK_COUNT)) begin
                            run_n   = '0;
                            state_n = LOCKED;
                        end else begin
                            run_n = run_inc;
                        end
                    end else if (in_word != '0) begin
                        expect_word_n = seed_next;
                        run_n         = '0;
                    end else begin
                        run_n   = '0;
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    expect_word_n = expect_step;
                    if (word_match) begin
                        run_n = '0;
                    end else begin
                        mismatch_n = 1'b1;
                        count_err  = 1'b1;
                        if (run_inc == RW'(UNLOCK_COUNT)) begin
                            run_n   = '0;
                            state_n = HUNT;
                        end else begin
                            run_n = run_inc;
                        end
                    end
                end
                default: begin
                    run_n   = '0;
                    state_n = HUNT;
                end
            endcase
        end
    end

    // The clear is applied first, so a clear that coincides with a counted
    // mismatch leaves the counter at one.
    always_comb begin
        err_base    = err_clear ? '0 : err_count;
        err_count_n = err_base;
        if (count_err && (err_base != '1)) begin
            err_count_n = err_base + ERR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
// Drives two checkers from the same stimulus. Both use WIDTH=4, TAPS=4'b0001,
// LOCK_COUNT=2 and UNLOCK_COUNT=3. One has a 16-bit error counter and the other
// a 2-bit counter, which lets the second one show saturation.
// Reference stream: 1,9,D,F,E,7,A,5,B,C,6,3,8,4,2,...
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

    typedef struct {
        string       name;
        logic        locked;
        logic        mismatch;
        logic [15:0] err;
        logic [1:0]  err_sat;
    } expect_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_word;
    logic        err_clear;
    logic        locked, locked_sat;
    logic        mismatch, mismatch_sat;
    logic [15:0] err_count;
    logic [1:0]  err_count_sat;

    expect_t scoreboard[$];
    int      compared   = 0;
    int      mismatched = 0;

    always #5 clock = ~clock;

    lfsr_checker #(
        .WIDTH(4), .TAPS(4'b0001), .LOCK_COUNT(2), .UNLOCK_COUNT(3), .ERR_WIDTH(16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .err_clear (err_clear),
        .locked    (locked),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    lfsr_checker #(
        .WIDTH(4), .TAPS(4'b0001), .LOCK_COUNT(2), .UNLOCK_COUNT(3), .ERR_WIDTH(2)
    ) dut_sat (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .err_clear (err_clear),
        .locked    (locked_sat),
        .mismatch  (mismatch_sat),
        .err_count (err_count_sat)
    );

    // Compare one expected entry against both DUT instances.
    task automatic checkOutput(input expect_t e);
        compared++;
        if (locked !== e.locked || mismatch !== e.mismatch || err_count !== e.err ||
            locked_sat !== e.locked || mismatch_sat !== e.mismatch ||
            err_count_sat !== e.err_sat) begin
            mismatched++;
            $display("[TB] FAIL %s: got locked=%b/%b mismatch=%b/%b err=%0d/%0d, want locked=%b mismatch=%b err=%0d/%0d",
                     e.name, locked, locked_sat, mismatch, mismatch_sat, err_count,
                     err_count_sat, e.locked, e.mismatch, e.err, e.err_sat);
        end
    endtask

    // Apply one cycle of stimulus and queue the outputs expected after that edge.
    task automatic applyStimulus(input string nm, input logic rst, input logic vld,
                                 input logic [3:0] wrd, input logic clr,
                                 input logic exp_locked, input logic exp_mm,
                                 input logic [15:0] exp_err, input logic [1:0] exp_err_sat);
        expect_t e;
        reset     = rst;
        in_valid  = vld;
        in_word   = wrd;
        err_clear = clr;
        @(posedge clock);
        e.name     = nm;
        e.locked   = exp_locked;
        e.mismatch = exp_mm;
        e.err      = exp_err;
        e.err_sat  = exp_err_sat;
        scoreboard.push_back(e);
        @(negedge clock);
    endtask

    // Monitor: the outputs are valid every cycle, so one entry is retired per
    // falling edge while entries are pending.
    initial begin
        forever begin
            @(negedge clock);
            if (scoreboard.size() > 0) checkOutput(scoreboard.pop_front());
        end
    end

    initial begin
        int budget;
        reset = 1'b1; in_valid = 1'b0; in_word = 4'h0; err_clear = 1'b0;
        @(negedge clock);

        //             name            rst vld word clr  L  M  err  sat
        applyStimulus("reset",         1, 1, 4'h5, 0,  0, 0, 0, 0);
        applyStimulus("acq_1",         0, 1, 4'h1, 0,  0, 0, 0, 0);
        applyStimulus("acq_9",         0, 1, 4'h9, 0,  0, 0, 0, 0);
        applyStimulus("acq_D_lock",    0, 1, 4'hD, 0,  1, 0, 0, 0);
        applyStimulus("fly_bad0",      0, 1, 4'h0, 0,  1, 1, 1, 1);
        applyStimulus("fly_gap",       0, 0, 4'h3, 0,  1, 0, 1, 1);
        applyStimulus("fly_bad5",      0, 1, 4'h5, 0,  1, 1, 2, 2);
        applyStimulus("fly_good7",     0, 1, 4'h7, 0,  1, 0, 2, 2);
        applyStimulus("reset_mid",     1, 1, 4'hA, 0,  0, 0, 0, 0);
        applyStimulus("post_rst_5",    0, 1, 4'h5, 0,  0, 0, 0, 0);
        applyStimulus("post_rst_B",    0, 1, 4'hB, 0,  0, 0, 0, 0);
        applyStimulus("post_rst_C",    0, 1, 4'hC, 0,  1, 0, 0, 0);
        applyStimulus("unlock_bad1",   0, 1, 4'h1, 0,  1, 1, 1, 1);
        applyStimulus("unlock_bad2",   0, 1, 4'h1, 0,  1, 1, 2, 2);
        applyStimulus("unlock_bad3",   0, 1, 4'h1, 0,  0, 1, 3, 3);
        applyStimulus("reseed_9",      0, 1, 4'h9, 0,  0, 0, 3, 3);
        applyStimulus("reseed_D",      0, 1, 4'hD, 0,  0, 0, 3, 3);
        applyStimulus("reseed_F_lock", 0, 1, 4'hF, 0,  1, 0, 3, 3);
        applyStimulus("sat_bad",       0, 1, 4'h0, 0,  1, 1, 4, 3);
        applyStimulus("sat_good7",     0, 1, 4'h7, 0,  1, 0, 4, 3);
        applyStimulus("sat_bad2",      0, 1, 4'h0, 0,  1, 1, 5, 3);
        applyStimulus("sat_good5",     0, 1, 4'h5, 0,  1, 0, 5, 3);
        applyStimulus("clear_alone",   0, 0, 4'h0, 1,  1, 0, 0, 0);
        applyStimulus("clear_and_bad", 0, 1, 4'h0, 1,  1, 1, 1, 1);
        applyStimulus("after_clr_C",   0, 1, 4'hC, 0,  1, 0, 1, 1);
        applyStimulus("reset_2",       1, 0, 4'h0, 0,  0, 0, 0, 0);
        applyStimulus("hunt_zero",     0, 1, 4'h0, 0,  0, 0, 0, 0);
        applyStimulus("seed_1",        0, 1, 4'h1, 0,  0, 0, 0, 0);
        applyStimulus("bad_seed_3",    0, 1, 4'h3, 0,  0, 0, 0, 0);
        applyStimulus("reseeded_8",    0, 1, 4'h8, 0,  0, 0, 0, 0);
        applyStimulus("verify_gap",    0, 0, 4'h6, 0,  0, 0, 0, 0);
        applyStimulus("lock_4",        0, 1, 4'h4, 0,  1, 0, 0, 0);
        applyStimulus("reset_3",       1, 0, 4'h0, 0,  0, 0, 0, 0);
        applyStimulus("v_seed_1",      0, 1, 4'h1, 0,  0, 0, 0, 0);
        applyStimulus("v_zero_hunt",   0, 1, 4'h0, 0,  0, 0, 0, 0);
        applyStimulus("h_seed_9",      0, 1, 4'h9, 0,  0, 0, 0, 0);
        applyStimulus("h_D",           0, 1, 4'hD, 0,  0, 0, 0, 0);
        applyStimulus("h_F_lock",      0, 1, 4'hF, 0,  1, 0, 0, 0);

        in_valid = 1'b0;
        budget   = 20;
        while (scoreboard.size() > 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (scoreboard.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", scoreboard.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
